// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the MIPS pipeline.
// Owns the PC, drives the instruction memory, and holds the IF/ID pipeline
// state (pc+4, valid, fault) in lockstep with the memory's output register,
// which acts as the IF/ID instruction latch.
// Optional feature macro: FETCH_PERF_EN adds perf_fetch / perf_stall counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
`endif
    output logic        ifid_fault
);

    localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    // PC arithmetic wraps modulo 2^32; the fault test is on the word index
    assign pc_plus4    = pc + 32'd4;
    assign fetch_fault = ({2'b00, pc[31:2]} >= DEPTH_WORDS);

    // Memory only reads when the fetched word will actually be latched;
    // a stalled cycle keeps readdata (the IF/ID instruction) frozen
    assign imem_addr  = {pc[31:2], 2'b00};
    assign imem_read  = rst_n & (~stall | redirect);
    assign ifid_instr = ifid_valid ? imem_rdata : 32'h0000_0000;

    // PC and IF/ID state update: redirect beats stall beats flush beats normal fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_pc4   <= 32'h0000_0000;
            ifid_valid <= 1'b0;
            ifid_fault <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc & ~32'h0000_0003;
            ifid_valid <= 1'b0;
            ifid_fault <= 1'b0;
        end else if (stall) begin
            pc         <= pc;
            ifid_pc4   <= ifid_pc4;
            ifid_valid <= ifid_valid;
            ifid_fault <= ifid_fault;
        end else if (flush) begin
            pc         <= pc_plus4;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_plus4;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= ~fetch_fault;
            ifid_fault <= fetch_fault;
        end
    end

`ifdef FETCH_PERF_EN
    // Count real instructions delivered to decode and cycles lost to hazard stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= 32'h0000_0000;
            perf_stall <= 32'h0000_0000;
        end else begin
            if (!redirect && !stall && !flush && !fetch_fault)
                perf_fetch <= perf_fetch + 32'd1;
            if (stall && !redirect)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, scoreboard-driven bench for fetch_unit.
// Each step drives the IF inputs for one cycle and queues the IF/ID contents
// expected after the following clock edge; the edge pops and compares them.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        ifid_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    logic [31:0] mem [0:255];

    int vectors;
    int miscompares;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .imem_read   (imem_read),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
`ifdef FETCH_PERF_EN
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
`endif
        .ifid_fault  (ifid_fault)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: registered read, readdata holds when memread is low
    always @(posedge clk) begin
        if (imem_read)
            imem_rdata <= mem[imem_addr[9:2]];
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs and queue the IF/ID state expected after the edge
    task automatic applyStimulus(input string tag, input logic st, input logic rd,
                                 input logic [31:0] rpc, input logic fl,
                                 input logic ev, input logic ef,
                                 input logic [31:0] ei, input logic [31:0] ep,
                                 input logic cp);
        exp_t e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        flush       = fl;
        e.valid   = ev;
        e.fault   = ef;
        e.instr   = ei;
        e.pc4     = ep;
        e.chk_pc4 = cp;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Clock one edge, then pop the scoreboard and compare away from the edge
    task automatic checkOutput();
        exp_t  e;
        string tag;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        checkVal({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
        checkVal({tag, ".fault"}, {31'd0, ifid_fault}, {31'd0, e.fault});
        checkVal({tag, ".instr"}, ifid_instr, e.instr);
        if (e.chk_pc4)
            checkVal({tag, ".pc4"}, ifid_pc4, e.pc4);
    endtask

    // Directed test sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++)
            mem[i] = 32'hC0DE_0000 | 32'(i);
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        flush       = 1'b0;

        // Reset state
        #12;
        checkVal("rst.valid", {31'd0, ifid_valid}, 32'd0);
        checkVal("rst.fault", {31'd0, ifid_fault}, 32'd0);
        checkVal("rst.pc4", ifid_pc4, 32'h0);
        checkVal("rst.instr", ifid_instr, 32'h0);
        checkVal("rst.read", {31'd0, imem_read}, 32'd0);
        checkVal("rst.addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        checkVal("rst.perf_fetch", perf_fetch, 32'd0);
        checkVal("rst.perf_stall", perf_stall, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkVal("t1.first_addr", imem_addr, 32'h0);
        checkVal("t1.first_read", {31'd0, imem_read}, 32'd1);

        // T1: sequential fetch A, B, C
        applyStimulus("t1.A", 0, 0, 32'h0, 0, 1, 0, mem[0], 32'h4, 1);
        checkOutput();
        applyStimulus("t1.B", 0, 0, 32'h0, 0, 1, 0, mem[1], 32'h8, 1);
        checkOutput();

        // T2: three stall cycles holding B, then C with no gap
        for (int k = 0; k < 3; k++) begin
            applyStimulus("t2.hold", 1, 0, 32'h0, 0, 1, 0, mem[1], 32'h8, 1);
            #1;
            checkVal("t2.read_low", {31'd0, imem_read}, 32'd0);
            checkOutput();
        end
        applyStimulus("t2.C", 0, 0, 32'h0, 0, 1, 0, mem[2], 32'hC, 1);
        checkOutput();
`ifdef FETCH_PERF_EN
        checkVal("t2.perf_fetch", perf_fetch, 32'd3);
        checkVal("t2.perf_stall", perf_stall, 32'd3);
`endif

        // T3: redirect to 0x40 from pc=0x0C, one bubble
        applyStimulus("t3.bubble", 0, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput();
        checkVal("t3.addr", imem_addr, 32'h40);
        applyStimulus("t3.target", 0, 0, 32'h0, 0, 1, 0, mem[16], 32'h44, 1);
        checkOutput();

        // T4: redirect with stall, unaligned target
        applyStimulus("t4.bubble", 1, 1, 32'h22, 0, 0, 0, 32'h0, 32'h0, 0);
        #1;
        checkVal("t4.read_high", {31'd0, imem_read}, 32'd1);
        checkOutput();
        checkVal("t4.addr", imem_addr, 32'h20);
        applyStimulus("t4.target", 0, 0, 32'h0, 0, 1, 0, mem[8], 32'h24, 1);
        checkOutput();

        // Flush squashes the entry but the PC keeps advancing
        applyStimulus("flush.bubble", 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h28, 1);
        checkOutput();
        applyStimulus("flush.next", 0, 0, 32'h0, 0, 1, 0, mem[10], 32'h2C, 1);
        checkOutput();

        // T5: last word valid, next word faults, pc keeps advancing
        applyStimulus("t5.bubble", 0, 1, 32'h3FC, 0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput();
        applyStimulus("t5.last", 0, 0, 32'h0, 0, 1, 0, mem[255], 32'h400, 1);
        checkOutput();
        applyStimulus("t5.fault", 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h404, 1);
        checkOutput();

        // PC wrap: 0xFFFFFFFC faults, then wraps to 0 and fetches mem[0]
        applyStimulus("wrap.bubble", 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput();
        applyStimulus("wrap.fault", 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 1);
        checkOutput();
        applyStimulus("wrap.zero", 0, 0, 32'h0, 0, 1, 0, mem[0], 32'h4, 1);
        checkOutput();

        // T6: reach pc=0x20 with a valid entry, stall, then async reset mid-cycle
        applyStimulus("t6.bubble", 0, 1, 32'h1C, 0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput();
        applyStimulus("t6.fetch", 0, 0, 32'h0, 0, 1, 0, mem[7], 32'h20, 1);
        checkOutput();
        applyStimulus("t6.stall", 1, 0, 32'h0, 0, 1, 0, mem[7], 32'h20, 1);
        checkOutput();
        checkVal("t6.pre_addr", imem_addr, 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("t6.rst_valid", {31'd0, ifid_valid}, 32'd0);
        checkVal("t6.rst_pc4", ifid_pc4, 32'h0);
        checkVal("t6.rst_instr", ifid_instr, 32'h0);
        checkVal("t6.rst_addr", imem_addr, 32'h0);
        checkVal("t6.rst_read", {31'd0, imem_read}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        applyStimulus("t6.refetch0", 0, 0, 32'h0, 0, 1, 0, mem[0], 32'h4, 1);
        checkOutput();
        applyStimulus("t6.refetch1", 0, 0, 32'h0, 0, 1, 0, mem[1], 32'h8, 1);
        checkOutput();
`ifdef FETCH_PERF_EN
        checkVal("t6.perf_fetch", perf_fetch, 32'd2);
        checkVal("t6.perf_stall", perf_stall, 32'd0);
`endif

        checkVal("sb.drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
